// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
// The PARITY state exists only when PISO_SERIALIZER_PARITY_EN is defined.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  // Bit-counter width for a frame of w data bits (w >= 2).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake plus serial output bundle around piso_serializer.
// The master side supplies words; the slave side is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = piso_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             serial;
  logic             frame;
  logic             last;

  modport master (
    output data,
    output valid,
    input  ready,
    input  serial,
    input  frame,
    input  last
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    output serial,
    output frame,
    output last
  );

endinterface

// File: rtl/piso_bitcnt.sv
// Frame bit counter: synchronous clear has priority over enable, and
// terminal flags the last data bit of a frame (count == WIDTH-1).
module piso_bitcnt
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready intake and
// optional even-parity trailer bit (PISO_SERIALIZER_PARITY_EN).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             frame_out,
  output logic             last_out
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             terminal;

  piso_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (terminal)
  );

  // ready_out depends only on state, so acceptance never feeds an output.
  assign accept     = valid_in && ready_out;
  assign cnt_clear  = accept;
  assign cnt_enable = (state_reg == SHIFT) && !terminal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_reg <= '0;
    end else if (accept) begin
      shreg_reg <= data_in;
    end else if (state_reg == SHIFT) begin
      shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^data_in;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    ready_out  = 1'b0;
    serial_out = 1'b0;
    frame_out  = 1'b0;
    last_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        frame_out  = 1'b1;
        serial_out = shreg_reg[WIDTH-1];
        if (terminal) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          last_out   = 1'b1;
          ready_out  = 1'b1;
          state_next = valid_in ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        frame_out  = 1'b1;
        serial_out = parity_reg;
        last_out   = 1'b1;
        ready_out  = 1'b1;
        state_next = valid_in ? SHIFT : IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=8); frame length follows
// PISO_SERIALIZER_PARITY_EN so the same vectors serve both builds.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
    logic       exp_par;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs [5];

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (bus.data),
    .valid_in   (bus.valid),
    .ready_out  (bus.ready),
    .serial_out (bus.serial),
    .frame_out  (bus.frame),
    .last_out   (bus.last)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, " ready"},  8'(bus.ready),  8'd1);
    check({nm, " serial"}, 8'(bus.serial), 8'd0);
    check({nm, " frame"},  8'(bus.frame),  8'd0);
    check({nm, " last"},   8'(bus.last),   8'd0);
  endtask

  // Present a word and wait (bounded) until it is taken; returns at the
  // falling edge of the first bit cycle with valid still asserted.
  task automatic offer(input logic [7:0] d, input string nm);
    int waited = 0;
    bus.data  = d;
    bus.valid = 1'b1;
    while (bus.ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({nm, " accept ready"}, 8'(bus.ready), 8'd1);
    @(negedge clk);
  endtask

  // Check one full frame starting at the falling edge of its first cycle.
  task automatic expect_frame(input logic [7:0] bits, input logic par,
                              input string nm, input bit scramble);
    for (int i = 0; i < FL; i++) begin
      logic exp_ser;
      logic is_last;
      is_last = (i == FL - 1);
      if (i < 8) exp_ser = bits[3'(7 - i)];
      else       exp_ser = par;
      check($sformatf("%s bit%0d serial", nm, i), 8'(bus.serial), 8'(exp_ser));
      check($sformatf("%s bit%0d frame", nm, i),  8'(bus.frame),  8'd1);
      check($sformatf("%s bit%0d last", nm, i),   8'(bus.last),   8'(is_last));
      check($sformatf("%s bit%0d ready", nm, i),  8'(bus.ready),  8'(is_last));
      if (scramble) begin
        if (!is_last) begin
          bus.data  = bus.data ^ 8'h5A;
          bus.valid = 1'b1;
        end else begin
          bus.valid = 1'b0;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0, "A5"};
    vecs[1] = '{8'h07, 8'b0000_0111, 1'b1, "07"};
    vecs[2] = '{8'h03, 8'b0000_0011, 1'b0, "03"};
    vecs[3] = '{8'h80, 8'b1000_0000, 1'b1, "80"};
    vecs[4] = '{8'h81, 8'b1000_0001, 1'b0, "81"};

    // Reset held 3 cycles with a word on offer: nothing may start.
    bus.data  = 8'hFF;
    bus.valid = 1'b1;
    reset     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle($sformatf("reset c%0d", c));
    end
    reset     = 1'b1;
    bus.valid = 1'b0;
    @(negedge clk);
    check_idle("post-reset");

    for (int v = 0; v < 5; v++) begin
      offer(vecs[v].data, vecs[v].name);
      bus.valid = 1'b0;
      expect_frame(vecs[v].exp_bits, vecs[v].exp_par, vecs[v].name, 1'b0);
      check_idle({vecs[v].name, " after"});
    end

    // Back-to-back frames: valid stays high across the frame boundary.
    offer(8'h3C, "b2b 3C");
    bus.data = 8'hC3;
    expect_frame(8'b0011_1100, 1'b0, "b2b 3C", 1'b0);
    bus.valid = 1'b0;
    expect_frame(8'b1100_0011, 1'b0, "b2b C3", 1'b0);
    check_idle("b2b after");

    // Reset after four bits of F0, then a clean 81 frame.
    offer(8'hF0, "mid F0");
    bus.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid F0 bit%0d serial", i), 8'(bus.serial), 8'(i < 4));
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    check_idle("mid reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid release");
    offer(8'h81, "mid 81");
    bus.valid = 1'b0;
    expect_frame(8'b1000_0001, 1'b0, "mid 81", 1'b0);
    check_idle("mid 81 after");

    // Upstream churns data/valid while ready is low; only C3 may appear.
    offer(8'hC3, "stall C3");
    expect_frame(8'b1100_0011, 1'b0, "stall C3", 1'b1);
    check_idle("stall after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port data_in, input, WIDTH bits: the parallel word to serialize.
REQ-005 SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-006 SHALL have port ready_out, output, 1 bit: the block accepts data_in this cycle.
REQ-007 SHALL have port serial_out, output, 1 bit: the serial bit stream, MSB first, so a downstream shift-left deserializer gets the word in original bit order.
REQ-008 SHALL have port frame_out, output, 1 bit: high on every cycle that serial_out carries a frame bit (data or parity).
REQ-009 SHALL have port last_out, output, 1 bit: high only on the final bit cycle of a frame.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY exists only when PARITY_EN is defined.
REQ-011 SHALL drive ready_out high in IDLE and on the final bit cycle of a frame; low otherwise.
REQ-012 SHALL accept a word at a rising edge where valid_in && ready_out; it loads data_in into the shift register, clears the bit counter and enters SHIFT.
REQ-013 SHALL ignore, and not sample, data_in/valid_in while ready_out is low; the upstream holds valid_in and data_in until accepted.
REQ-014 SHALL drive serial_out = shreg[WIDTH-1] in SHIFT; each edge shifts shreg left by one and increments the counter (width clog2(WIDTH)).
REQ-015 SHALL present data_in[WIDTH-1] on serial_out in the cycle after acceptance (latency 1); data_in[0] appears WIDTH cycles after acceptance.
REQ-016 SHALL, at the edge ending the last data bit (counter == WIDTH-1), go to PARITY if enabled; otherwise go to SHIFT with a new word if one is accepted that edge, else to IDLE.
REQ-017 SHALL, in PARITY, drive serial_out with the even-parity bit (XOR of the accepted word) for one cycle; the exit edge goes to SHIFT on acceptance, else to IDLE.
REQ-018 SHALL support back-to-back frames with no idle gap when valid_in is high on the final bit cycle.
REQ-019 SHALL drive serial_out, frame_out and last_out to 0 in IDLE.
REQ-020 SHALL compute outputs combinationally from registered state only; there is no combinational path from valid_in to any output.

Reset
REQ-021 SHALL, when reset is low at a rising edge, enter IDLE, clear shreg, the counter and the parity register, and discard any frame in progress.
REQ-022 SHALL hold reset values ready_out=1 and serial_out=frame_out=last_out=0 from the cycle after the reset edge.
REQ-023 SHALL give reset priority over a simultaneous acceptance; the word is not loaded.

Configuration
REQ-024 SHALL, when macro PISO_SERIALIZER_PARITY_EN is defined, append one even-parity bit, giving frames of WIDTH+1 cycles with last_out on the parity bit.
REQ-025 SHALL, when PISO_SERIALIZER_PARITY_EN is undefined, omit the PARITY state and parity register, giving frames of WIDTH cycles with last_out on data bit 0.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE/SHIFT/PARITY) and the default WIDTH constant in shared package piso_pkg.
REQ-027 SHALL implement the bit counter as sub-module piso_bitcnt (clear, enable, terminal-count flag); the shift register and FSM stay in piso_serializer.

Verification
REQ-028 SHALL cover reset: hold reset low 3 cycles with valid_in=1 and data_in=8'hFF -> ready_out=1, serial_out=0, frame_out=0, and no frame starts.
REQ-029 SHALL cover a single frame: accept 8'hA5 without parity -> serial_out 1,0,1,0,0,1,0,1 over cycles 1-8, frame_out high for 8 cycles, last_out on cycle 8 only.
REQ-030 SHALL cover back-to-back frames: 8'h3C then 8'hC3 with valid_in held high -> 16 consecutive frame_out cycles with no gap and the bit stream 00111100_11000011.
REQ-031 SHALL cover parity: with PARITY_EN defined, accept 8'h07 -> 9-cycle frame ending in parity bit 1; accept 8'h03 -> parity bit 0.
REQ-032 SHALL cover mid-frame reset: assert reset after 4 bits of 8'hF0 -> IDLE next cycle, outputs 0, and the next accepted word 8'h81 is emitted intact.
REQ-033 SHALL cover a stalled upstream: change data_in while ready_out is low -> the serial stream matches only the originally accepted word.
